// File: rtl/kore_func_pkg.sv
// kore_func_pkg: shared types and sizes for the kore_func command engine.
//   - opcode enum (kore_op_e), FSM state enum (kore_state_e)
//   - KORE_REG_NUM / KORE_DATA_W / KORE_ADDR_W sizing constants
//   - op_writes(): true for every opcode that updates the register bank
package kore_func_pkg;

  localparam int KORE_REG_NUM = 32;
  localparam int KORE_DATA_W  = 32;
  localparam int KORE_ADDR_W  = $clog2(KORE_REG_NUM);

  typedef enum logic [2:0] {
    OP_WR  = 3'd0,
    OP_RD  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_ILL = 3'd7
  } kore_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } kore_state_e;

  function automatic logic op_writes(input kore_op_e op);
    return (op != OP_RD) && (op != OP_ILL);
  endfunction

endpackage

// File: rtl/kore_func_alu.sv
// kore_func_alu: combinational datapath for kore_func_fsm.
// Ports:
//   op_i      opcode
//   a_i       operand A (register bank value)
//   b_i       operand B (command data)
//   result_o  32-bit wrap-around result
//   carry_o   carry-out (ADD) / borrow (SUB), 0 otherwise;
//             present only when KORE_FUNC_CARRY_EN is defined
module kore_func_alu
  import kore_func_pkg::*;
(
  input  kore_op_e               op_i,
  input  logic [KORE_DATA_W-1:0] a_i,
  input  logic [KORE_DATA_W-1:0] b_i,
`ifdef KORE_FUNC_CARRY_EN
  output logic                   carry_o,
`endif
  output logic [KORE_DATA_W-1:0] result_o
);

`ifdef KORE_FUNC_CARRY_EN
  // one extra bit: MSB is carry for ADD and borrow for SUB
  logic [KORE_DATA_W:0] wide;
`endif

  always_comb begin
    result_o = '0;
`ifdef KORE_FUNC_CARRY_EN
    wide    = '0;
    carry_o = 1'b0;
`endif
    case (op_i)
      OP_WR:  result_o = b_i;
      OP_RD:  result_o = a_i;
`ifdef KORE_FUNC_CARRY_EN
      OP_ADD: begin
        wide     = {1'b0, a_i} + {1'b0, b_i};
        result_o = wide[KORE_DATA_W-1:0];
        carry_o  = wide[KORE_DATA_W];
      end
      OP_SUB: begin
        wide     = {1'b0, a_i} - {1'b0, b_i};
        result_o = wide[KORE_DATA_W-1:0];
        carry_o  = wide[KORE_DATA_W];
      end
`else
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
`endif
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/kore_func_fsm.sv
// kore_func_fsm: single-command engine that reads/modifies/writes an
// external 32x32 register bank and returns one response per command.
// Optional feature macro: KORE_FUNC_CARRY_EN (adds rsp_carry output).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_op/cmd_addr/cmd_data payload
//   rsp_valid/rsp_ready  response handshake; rsp_data, rsp_err, rsp_carry
//   reg_sel, din, wt_en  register bank select / write data / write strobe
//   dout                 register bank read data for reg_sel
//   busy                 high whenever a command is in flight
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | cmd_ready=1, waiting for a command
// ST_FETCH | reg_sel=addr, latch dout as operand A; illegal op -> RESP
// ST_EXEC  | compute result, one-cycle write strobe unless RD
// ST_RESP  | hold response until rsp_ready
module kore_func_fsm
  import kore_func_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [KORE_ADDR_W-1:0] cmd_addr,
  input  logic [KORE_DATA_W-1:0] cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [KORE_DATA_W-1:0] rsp_data,
  output logic                   rsp_err,
`ifdef KORE_FUNC_CARRY_EN
  output logic                   rsp_carry,
`endif
  output logic [KORE_ADDR_W-1:0] reg_sel,
  output logic [KORE_DATA_W-1:0] din,
  output logic                   wt_en,
  input  logic [KORE_DATA_W-1:0] dout,
  output logic                   busy
);

  kore_state_e            state_q, state_d;
  kore_op_e               op_q, op_d;
  logic [KORE_ADDR_W-1:0] addr_q, addr_d;
  logic [KORE_DATA_W-1:0] a_q, a_d;
  logic [KORE_DATA_W-1:0] b_q, b_d;
  logic [KORE_DATA_W-1:0] res_q, res_d;
  logic                   err_q, err_d;
  logic [KORE_DATA_W-1:0] alu_res;
`ifdef KORE_FUNC_CARRY_EN
  logic                   carry_q, carry_d;
  logic                   alu_carry;
`endif

  kore_func_alu u_alu (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
`ifdef KORE_FUNC_CARRY_EN
    .carry_o  (alu_carry),
`endif
    .result_o (alu_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_WR;
      addr_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef KORE_FUNC_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef KORE_FUNC_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
`ifdef KORE_FUNC_CARRY_EN
    carry_d = carry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = kore_op_e'(cmd_op);
          addr_d  = cmd_addr;
          b_d     = cmd_data;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        a_d = dout;
        if (op_q == OP_ILL) begin
          res_d   = '0;
          err_d   = 1'b1;
`ifdef KORE_FUNC_CARRY_EN
          carry_d = 1'b0;
`endif
          state_d = ST_RESP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_res;
        err_d   = 1'b0;
`ifdef KORE_FUNC_CARRY_EN
        carry_d = alu_carry;
`endif
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs decode from registered state only.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    reg_sel   = addr_q;
    wt_en     = (state_q == ST_EXEC) && op_writes(op_q);
    // din is forced to zero whenever the strobe is low, including RD in EXEC
    din       = wt_en ? alu_res : '0;
    rsp_data  = rsp_valid ? res_q : '0;
    rsp_err   = rsp_valid & err_q;
`ifdef KORE_FUNC_CARRY_EN
    rsp_carry = rsp_valid & carry_q;
`endif
  end

endmodule

// File: doc/kore_func_fsm.md
KORE_FUNC_FSM -- requirements
Module: kore_func_fsm

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 cmd_valid  input  1  command request.
REQ-004 cmd_ready  output  1  block can accept a command.
REQ-005 cmd_op  input  3  opcode: 0 WR, 1 RD, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 illegal.
REQ-006 cmd_addr  input  5  target register index, 0..31.
REQ-007 cmd_data  input  32  operand B / write data.
REQ-008 rsp_valid  output  1  response available.
REQ-009 rsp_ready  input  1  response consumer ready.
REQ-010 rsp_data  output  32  response word.
REQ-011 rsp_err  output  1  illegal-opcode flag.
REQ-012 rsp_carry  output  1  carry/borrow of ADD/SUB; present only with KORE_FUNC_CARRY_EN.
REQ-013 reg_sel  output  5  to register bank select.
REQ-014 din  output  32  to register bank write data.
REQ-015 wt_en  output  1  to register bank write strobe.
REQ-016 dout  input  32  combinational read data from register bank for reg_sel.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States IDLE, FETCH, EXEC, RESP; one command in flight at most.
REQ-019 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready capture op/addr/data, go FETCH; no other state asserts cmd_ready.
REQ-020 FETCH: reg_sel=captured addr; register dout as operand A; legal op -> EXEC; op 7 -> RESP with rsp_err=1, rsp_data=0, no write.
REQ-021 EXEC: result WR=B, RD=A, ADD=A+B, SUB=A-B, AND/OR/XOR bitwise; 32-bit wrap-around, no saturation.
REQ-022 EXEC: for every op except RD, wt_en=1 for exactly one cycle with din=result, reg_sel=captured addr; then RESP.
REQ-023 RESP: rsp_valid=1, rsp_data=result (RD: old value; write ops: new value), held stable until rsp_valid&&rsp_ready, then IDLE.
REQ-024 Latency: legal op rsp_valid rises 3 edges after accepting edge; illegal op 2 edges; next command acceptable the cycle after the response handshake.
REQ-025 wt_en, din, reg_sel decode from internal registers only; no combinational path from any input to any output.
REQ-026 wt_en=0 and din=0 in all states except EXEC; reg_sel keeps last captured addr in IDLE.
REQ-027 rsp_ready high before RESP has no effect; cmd_valid during busy is ignored (not captured, not lost by this block -- upstream holds it).

Reset
REQ-028 rst asserted: state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_carry=0, wt_en=0, din=0, reg_sel=0, busy=0.
REQ-029 rst mid-command aborts it: no wt_en pulse and no response issued for that command.

Configuration
REQ-030 KORE_FUNC_CARRY_EN defined: rsp_carry port exists; carry-out for ADD, borrow for SUB, 0 for other ops, registered in EXEC, valid with rsp_valid.
REQ-031 KORE_FUNC_CARRY_EN undefined: rsp_carry port and its logic absent; all other behaviour identical.

Structure
REQ-032 Package kore_func_pkg holds opcode enum, state enum, KORE_REG_NUM=32, KORE_DATA_W=32, KORE_ADDR_W=5.
REQ-033 Sub-module kore_func_alu: combinational op/A/B -> result (and carry when enabled); FSM and handshakes stay in kore_func_fsm.

Verification
REQ-034 WR addr 3 data 0xDEADBEEF -> single wt_en pulse, reg_sel=3, din=0xDEADBEEF; rsp_data=0xDEADBEEF 3 edges after accept.
REQ-035 Bank reg 5=0xFFFFFFFF, ADD addr 5 data 1 -> din=0x00000000, rsp_data=0, rsp_carry=1 (macro on).
REQ-036 RD addr 7 holding 0x12345678 -> no wt_en, rsp_data=0x12345678.
REQ-037 op 7 addr 2 -> no wt_en, rsp_err=1, rsp_data=0, rsp_valid 2 edges after accept.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, second cmd_valid not accepted until handshake.
REQ-039 rst pulsed while in FETCH of WR addr 9 -> reg 9 unchanged, no response, all outputs at reset values.
